// File: rtl/pipo_rr_load_arbiter.sv
// Round-robin arbiter for a shared PIPO load register.
// Each access runs grant/load (WRITE) and then ack (ACK); at most one write every 3 cycles.
module pipo_rr_load_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 4,
  parameter int CNTW  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] wdata,
  output logic [NREQ-1:0]       gnt,
  output logic [NREQ-1:0]       ack,
  output logic                  load_o,
  output logic [WIDTH-1:0]      d_o,
  output logic                  busy,
  output logic [CNTW-1:0]       wr_count
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {IDLE, WRITE, ACK} state_t;

  state_t            state_q, state_d;
  logic [PW-1:0]     ptr_q, ptr_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic [NREQ-1:0]   ack_q, ack_d;
  logic [WIDTH-1:0]  d_q, d_d;
  logic [CNTW-1:0]   cnt_q, cnt_d;

  logic [PW-1:0]     win;
  logic [PW-1:0]     idx;
  logic              found;

  // The scan starts just past the last winner, so the most recently served requester is checked last.
  always_comb begin
    win   = '0;
    idx   = '0;
    found = 1'b0;
    for (int i = 1; i <= NREQ; i++) begin
      idx = PW'((int'(ptr_q) + i) % NREQ);
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    ack_d   = '0;
    d_d     = d_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        gnt_d = '0;
        if (found) begin
          gnt_d   = NREQ'(1) << win;
          d_d     = wdata[int'(win)*WIDTH +: WIDTH];
          ptr_d   = win;
          state_d = WRITE;
        end
      end
      WRITE: begin
        ack_d   = gnt_q;
        state_d = ACK;
      end
      ACK: begin
        gnt_d   = '0;
        state_d = IDLE;
        if (cnt_q != '1) cnt_d = cnt_q + CNTW'(1);
      end
      default: begin
        gnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= PW'(NREQ - 1);
      gnt_q   <= '0;
      ack_q   <= '0;
      d_q     <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      ack_q   <= ack_d;
      d_q     <= d_d;
      cnt_q   <= cnt_d;
    end
  end

  // load_o and busy decode straight from state, so an asynchronous reset drops them at once.
  assign load_o   = (state_q == WRITE);
  assign busy     = (state_q != IDLE);
  assign gnt      = gnt_q;
  assign ack      = ack_q;
  assign d_o      = d_q;
  assign wr_count = cnt_q;
endmodule

// File: tb/tb_pipo_rr_load_arbiter.sv
// Randomized and directed bench for pipo_rr_load_arbiter.
// It checks the DUT against a transaction-level round-robin model.
module tb_pipo_rr_load_arbiter;
  localparam int NREQ  = 4;
  localparam int WIDTH = 4;
  localparam int CNTW  = 8;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic [NREQ-1:0]       req = '0;
  logic [NREQ*WIDTH-1:0] wdata = '0;
  logic [NREQ-1:0]       gnt, ack;
  logic                  load_o, busy;
  logic [WIDTH-1:0]      d_o;
  logic [CNTW-1:0]       wr_count;

  pipo_rr_load_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .CNTW(CNTW)) dut (
    .clk(clk), .rst(rst), .req(req), .wdata(wdata), .gnt(gnt), .ack(ack),
    .load_o(load_o), .d_o(d_o), .busy(busy), .wr_count(wr_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%0h exp=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Model: m_t counts cycles into a transfer (0 idle, 1 write, 2 ack).
  int               m_t, m_w, m_ptr, m_cnt, m_win;
  logic [WIDTH-1:0] m_d;

  function automatic int pick(input int p, input logic [NREQ-1:0] r);
    for (int i = 1; i <= NREQ; i++)
      if (r[(p + i) % NREQ]) return (p + i) % NREQ;
    return 0;
  endfunction

  always_comb m_win = pick(m_ptr, req);

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_t <= 0; m_w <= 0; m_ptr <= NREQ - 1; m_cnt <= 0; m_d <= '0;
    end else begin
      case (m_t)
        0: if (req != '0) begin
          m_w   <= m_win;
          m_ptr <= m_win;
          m_d   <= wdata[m_win*WIDTH +: WIDTH];
          m_t   <= 1;
        end
        1: m_t <= 2;
        default: begin
          m_t <= 0;
          if (m_cnt < (1 << CNTW) - 1) m_cnt <= m_cnt + 1;
        end
      endcase
    end
  end

  always @(negedge clk) begin
    chk("gnt",  gnt,      (m_t != 0) ? (1 << m_w) : 0);
    chk("ack",  ack,      (m_t == 2) ? (1 << m_w) : 0);
    chk("load", load_o,   m_t == 1);
    chk("busy", busy,     m_t != 0);
    chk("d_o",  d_o,      m_d);
    chk("cnt",  wr_count, m_cnt);
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #12 rst = 1'b0;
    cyc(1);
    cyc(5);                                   // idle, no requests

    wdata = 16'h0A00; req = 4'b0100;          // single write from requester 2
    cyc(1); req = '0; cyc(4);
    chk("single_cnt", wr_count, 1);

    for (int i = 0; i < NREQ; i++) wdata[i*WIDTH +: WIDTH] = WIDTH'(1 << i);
    req = 4'b1111; cyc(15); req = '0; cyc(3);

    rst = 1'b1; #2 rst = 1'b0;                // fresh pointer, then 1001
    req = 4'b1001;
    cyc(1); chk("ord0", gnt, 4'b0001);
    cyc(3); chk("ord1", gnt, 4'b1000);
    cyc(3); chk("ord2", gnt, 4'b0001);
    req = '0; cyc(3);

    wdata = 16'h0060; req = 4'b0010;          // request dropped during WRITE
    cyc(1); req = '0; wdata = 16'hFFFF;
    cyc(1); chk("drop_ack", ack, 4'b0010); chk("drop_d", d_o, 4'b0110);
    cyc(3);

    req = 4'b0010;                            // reset mid-WRITE
    @(posedge clk); #2;
    chk("pre_load", load_o, 1'b1);
    rst = 1'b1; #1;
    chk("rst_load", load_o, 1'b0); chk("rst_gnt", gnt, 0);
    chk("rst_busy", busy, 1'b0);   chk("rst_ack", ack, 0);
    chk("rst_cnt", wr_count, 0);
    @(negedge clk); rst = 1'b0; req = 4'b0001; wdata = 16'h0005;
    cyc(1); chk("post_gnt", gnt, 4'b0001); req = '0;
    cyc(4); chk("post_cnt", wr_count, 1);

    for (int k = 0; k < 600; k++) begin       // random traffic
      req   = ($urandom_range(0, 3) == 0) ? '0 : NREQ'($urandom);
      wdata = (NREQ*WIDTH)'($urandom);
      cyc(1);
    end

    req = '1;                                 // drive the counter into saturation
    cyc(800);
    chk("sat_cnt", wr_count, (1 << CNTW) - 1);
    req = '0; cyc(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pipo_rr_load_arbiter.md
Name: pipo_rr_load_arbiter

Overview:
- Shares one parallel-in/parallel-out load register among NREQ requesters using fair round-robin arbitration.
- Sequences each access: grant, single-cycle load strobe with captured data to the register's d/load inputs, then a one-cycle ack to the winner.
- Sits between requester blocks and the shared PIPO register; the register itself stays outside this block.

Parameters:
- NREQ, 4, number of requesters (2..8).
- WIDTH, 4, data width of the shared register.
- CNTW, 8, width of the completed-write counter.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- req  input  NREQ  level request per requester; bit i = requester i.
- wdata  input  NREQ*WIDTH  requester i data in bits [i*WIDTH +: WIDTH].
- gnt  output  NREQ  registered one-hot grant; all zero when idle.
- ack  output  NREQ  registered one-cycle pulse to the served requester after its write.
- load_o  output  1  load strobe to the shared register.
- d_o  output  WIDTH  data to the shared register's d input.
- busy  output  1  high in WRITE and ACK states.
- wr_count  output  CNTW  saturating count of completed writes.

Behaviour:
- Reset is asynchronous and active-high on rst; clock is clk.
- Reset values:
  - state = IDLE; gnt = 0, ack = 0, load_o = 0, d_o = 0, busy = 0, wr_count = 0.
  - Round-robin pointer ptr = NREQ-1, so requester 0 has first priority.
- FSM states: IDLE, WRITE, ACK.
- IDLE:
  - If req is nonzero at the clock edge, choose winner w as the first set bit scanning ptr+1, ptr+2, ... modulo NREQ.
  - At that same edge: gnt <= onehot(w), d_o <= wdata slice w, ptr <= w, go to WRITE.
  - If req == 0, stay in IDLE; outputs stay zero except d_o, which holds its last value.
- WRITE (exactly 1 cycle):
  - load_o = 1 and busy = 1; gnt and d_o held.
  - The register captures d_o at the edge that ends WRITE.
  - Next state is ACK.
- ACK (exactly 1 cycle):
  - ack[w] = 1; gnt holds onehot(w); load_o = 0; busy = 1.
  - wr_count increments, saturating at 2^CNTW-1.
  - Next state is IDLE; gnt clears on that edge.
- Latency and throughput:
  - req sampled at edge E: gnt at E+, load_o high in cycle E+1, ack high in cycle E+2, back in IDLE at E+3.
  - Maximum throughput is one write per 3 cycles.
- Requester handshake:
  - wdata must be valid at the edge where req is sampled; later changes are ignored.
  - A requester holding req high after ack is a new request and competes by round-robin.
  - req deasserting during WRITE/ACK does not abort; the write completes and ack is still issued.
  - req changes during WRITE/ACK are not evaluated until IDLE.
- Fairness: with all req bits constantly high, grants rotate 0,1,2,3,0,... With a single requester it is granted every 3 cycles.
- Invariants:
  - gnt is one-hot or zero; ack is one-hot or zero; ack bit always equals the current gnt bit.
  - load_o is never high outside WRITE.
- Reset mid-operation:
  - Immediately forces the reset values and abandons any pending write.
  - If rst asserts during WRITE, load_o drops asynchronously; the register write is undefined but no ack is issued.
  - ptr returns to NREQ-1.
- wr_count counts ACK cycles only, so aborted transfers are not counted.

Test Plan:
- Reset, then req=4'b0000 for 5 cycles -> gnt=0, load_o never high, wr_count=0.
- req=4'b0100, wdata slice2=4'b1010 -> gnt=4'b0100 next cycle, load_o=1 with d_o=1010 one cycle later, ack=4'b0100 the following cycle, wr_count=1.
- req=4'b1111 held, slices i=4'b0001<<i -> grant order 0,1,2,3,0, d_o sequence 0001,0010,0100,1000,0001, one write per 3 cycles.
- Out of reset, req=4'b1001 -> requester 0 granted first; keep both high -> requester 3 next, then 0.
- req=4'b0010 dropped during WRITE -> write of captured data completes, ack=4'b0010 still pulses, then IDLE.
- rst asserted mid-WRITE -> load_o, gnt, busy go 0 without a clock edge, no ack, wr_count=0; after release, req=4'b0001 is served normally.
